router_fsm: RTL
===============

Name: router_fsm

Overview:
- Control FSM for the 1x3 router. Sequences the router register block (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the write side of the three output FIFOs.
- Decodes the 2-bit destination from the header byte, stalls the source via busy, and handles FIFO-full pauses and parity-check sequencing.
- Sits between the input port and router_reg / router_sync.

Parameters:
WAIT_TIMEOUT, 30, cycles allowed in WAIT_TILL_EMPTY before abort (used only with optional feature)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pkt_valid  input  1  source packet valid
data_in  input  2  header destination bits; 0/1/2 valid, 3 invalid
fifo_full  input  1  full flag of the currently selected FIFO
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
soft_reset_0  input  1  FIFO 0 read-timeout soft reset
soft_reset_1  input  1  FIFO 1 read-timeout soft reset
soft_reset_2  input  1  FIFO 2 read-timeout soft reset
parity_done  input  1  from register block
low_pkt_valid  input  1  from register block
write_enb_reg  output  1  FIFO write enable
detect_add  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
rst_int_reg  output  1  in CHECK_PARITY_ERROR
busy  output  1  source must hold data
timeout_abort  output  1  one-cycle pulse; constant 0 without optional feature

Behaviour:
- All interface signals are on one clock. Reset is asynchronous and active-high.
- Reset forces state to DECODE_ADDRESS and addr_q to 0. Resulting outputs: detect_add=1; all other outputs 0.
- Outputs are Moore, decoded from registered state, so an output changes 1 cycle after the causing input edge.
- addr_q latches data_in when in DECODE_ADDRESS with pkt_valid=1. tgt_empty and tgt_soft are selected by addr_q.
- Transitions; the first matching rule wins:
  - Any state: tgt_soft=1 -> DECODE_ADDRESS. This takes priority over all other transitions.
  - DECODE_ADDRESS, with pkt_valid=1 and data_in!=3:
    - selected fifo_empty_x=1 -> LOAD_FIRST_DATA
    - otherwise -> WAIT_TILL_EMPTY
    - data_in==3 or pkt_valid=0 -> stay.
  - WAIT_TILL_EMPTY: tgt_empty=1 -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  - LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay. fifo_full wins when both conditions hold.
  - FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done=1 -> DECODE_ADDRESS
    - else low_pkt_valid=1 -> LOAD_PARITY
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- Output decode:
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
  - busy = every state except DECODE_ADDRESS and LOAD_DATA
  - each *_state / detect_add / rst_int_reg output is the one-hot decode of its own state.
- State encoding is 3-bit binary. Unreachable codes go to DECODE_ADDRESS on the next clock.
- Reset asserted mid-packet returns the block immediately (asynchronously) to the reset values above.
- Soft reset of a non-selected FIFO has no effect.

Optional Feature:
- Macro ROUTER_FSM_TIMEOUT_EN.
- Defined:
  - Adds a counter that clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - If the counter reaches WAIT_TIMEOUT while tgt_empty=0: state -> DECODE_ADDRESS and timeout_abort pulses high for 1 cycle.
  - tgt_soft keeps priority over the timeout.
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; timeout_abort is tied to 0.

Test Plan:
1. Reset high, then low; idle 5 cycles -> detect_add=1, busy=0, all other outputs 0.
2. pkt_valid=1, data_in=1, fifo_empty_1=1; 4 payload bytes; pkt_valid drops -> state path DECODE -> LFD -> LD x4 -> LP -> CPE -> DECODE; write_enb_reg high for 5 cycles; busy high in LFD, LP, CPE.
3. fifo_full asserted during the 2nd LD cycle for 3 cycles -> FIFO_FULL_STATE for 3 cycles with full_state=1 and busy=1, then LAF. With low_pkt_valid=0 and parity_done=0 -> returns to LD.
4. data_in=2, fifo_empty_2=0 for 6 cycles, then 1 -> WAIT_TILL_EMPTY for 6 cycles, then LFD; addr_q stays 2 even if data_in changes meanwhile.
5. Packet to FIFO 0, soft_reset_0 pulsed in LD -> next state DECODE_ADDRESS. Repeat with soft_reset_2 pulsed -> no state change.
6. With ROUTER_FSM_TIMEOUT_EN and WAIT_TIMEOUT=30, target never empties -> after 30 cycles in WAIT_TILL_EMPTY: DECODE_ADDRESS and timeout_abort=1 for exactly 1 cycle. Without the macro -> remains in WAIT_TILL_EMPTY at cycle 100.

Source files
------------

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: header decode, FIFO write sequencing, busy stall and parity-check hand-off.
// Optional macro ROUTER_FSM_TIMEOUT_EN aborts WAIT_TILL_EMPTY after WAIT_TIMEOUT cycles and pulses timeout_abort.
module router_fsm #(
    parameter int WAIT_TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       timeout_abort
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       tgt_empty, tgt_soft, din_empty;

    if (WAIT_TIMEOUT < 1) begin : g_bad_timeout
        $error("router_fsm: WAIT_TIMEOUT must be at least 1");
    end

    // Destination 3 has no FIFO behind it: never empty, never soft-reset.
    always_comb begin
        tgt_empty = 1'b0;
        tgt_soft  = 1'b0;
        case (addr_q)
            2'd0: begin tgt_empty = fifo_empty_0; tgt_soft = soft_reset_0; end
            2'd1: begin tgt_empty = fifo_empty_1; tgt_soft = soft_reset_1; end
            2'd2: begin tgt_empty = fifo_empty_2; tgt_soft = soft_reset_2; end
            default: ;
        endcase
    end

    always_comb begin
        din_empty = 1'b0;
        case (data_in)
            2'd0:    din_empty = fifo_empty_0;
            2'd1:    din_empty = fifo_empty_1;
            2'd2:    din_empty = fifo_empty_2;
            default: din_empty = 1'b0;
        endcase
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             abort_q, abort_d, tmo_hit;

    // tmo_hit marks the WAIT_TIMEOUT-th consecutive cycle in WAIT_TILL_EMPTY.
    assign tmo_hit    = (state_q == WAIT_TILL_EMPTY) && (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
    assign wait_cnt_d = (state_q == WAIT_TILL_EMPTY) ? wait_cnt_q + CNT_W'(1) : '0;
    assign abort_d    = tmo_hit && !tgt_empty && !tgt_soft;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
        end
    end

    assign timeout_abort = abort_q;
`else
    assign timeout_abort = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == DECODE_ADDRESS && pkt_valid) begin
            addr_d = data_in;
        end
        if (tgt_soft) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3) begin
                        state_d = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (tgt_empty) begin
                        state_d = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state_d = DECODE_ADDRESS;
`endif
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        state_d = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule
